pwm_frame_tx: RTL and testbench

Parametrised pulse-width-encoded single-wire frame transmitter with a valid/ready input and a one-word holding register. It serialises DATA_WIDTH-bit words MSB first, with an optional even-parity bit, between start and end sync symbols. A configurable idle gap separates frames, so consecutive frames go out back-to-back without upstream stalls. It sits between the frame-building logic and the output pin.

---
 rtl/pwm_frame_tx.sv | 166 ++++++++++++++++
 tb/tb_pwm_frame_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_frame_tx.sv
// rtl/pwm_frame_tx.sv - pulse-width-encoded single-wire frame transmitter with one-word holding register
module pwm_frame_tx #(
    parameter int DATA_WIDTH = 26,
    parameter int BIT_PERIOD = 20,
    parameter int ZERO_LOW   = 5,
    parameter int SYNC_LOW   = 10,
    parameter int ONE_LOW    = 15,
    parameter int PARITY_EN  = 0,
    parameter int IDLE_GAP   = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_out,
    output logic                  data_out,
    output logic                  busy_out,
    output logic                  done_out
);
    localparam int CW = $clog2(BIT_PERIOD + 1);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] LOW_ZERO = CW'(ZERO_LOW);
    localparam logic [CW-1:0] LOW_SYNC = CW'(SYNC_LOW);
    localparam logic [CW-1:0] LOW_ONE  = CW'(ONE_LOW);
    localparam logic [BW-1:0] BIT_TOP  = BW'(DATA_WIDTH - 1);
    // Only meaningful when IDLE_GAP > 0; the GAP state is unreachable otherwise.
    localparam logic [7:0]    GAP_LAST = 8'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_END,
        S_GAP
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [BW-1:0]         bit_idx, bit_idx_nxt;
    logic [7:0]            gap_cnt, gap_cnt_nxt;
    logic [DATA_WIDTH-1:0] hold_reg, shift_reg, shift_nxt;
    logic                  hold_full, parity_reg, parity_nxt;
    logic                  load_start, sym_end;
    logic [CW-1:0]         low_nxt;
    logic                  line_nxt;

    assign ready_out = !hold_full;
    assign busy_out  = (state != S_IDLE);
    assign sym_end   = (cnt == CNT_LAST);

    // Sequencing: symbol counter, bit index, gap counter and the drain of the holding register.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = sym_end ? '0 : cnt + 1'b1;
        bit_idx_nxt = bit_idx;
        gap_cnt_nxt = gap_cnt;
        shift_nxt   = shift_reg;
        parity_nxt  = parity_reg;
        load_start  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (hold_full) begin
                    state_nxt  = S_START;
                    load_start = 1'b1;
                end
            end
            S_START: begin
                if (sym_end) begin
                    state_nxt   = S_DATA;
                    bit_idx_nxt = BIT_TOP;
                end
            end
            S_DATA: begin
                if (sym_end) begin
                    shift_nxt = shift_reg << 1;
                    if (bit_idx == '0) begin
                        state_nxt = (PARITY_EN != 0) ? S_PARITY : S_END;
                    end else begin
                        bit_idx_nxt = bit_idx - 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (sym_end) state_nxt = S_END;
            end
            S_END: begin
                if (sym_end) begin
                    if (IDLE_GAP > 0) begin
                        state_nxt   = S_GAP;
                        gap_cnt_nxt = '0;
                    end else if (hold_full) begin
                        state_nxt  = S_START;
                        load_start = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                cnt_nxt = '0;
                if (gap_cnt == GAP_LAST) begin
                    if (hold_full) begin
                        state_nxt  = S_START;
                        load_start = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (load_start) begin
            shift_nxt  = hold_reg;
            parity_nxt = ^hold_reg;
            cnt_nxt    = '0;
        end
    end

    // Line level for the coming cycle: low while the symbol counter is below the symbol's low length.
    always_comb begin
        low_nxt = '0;
        case (state_nxt)
            S_START, S_END: low_nxt = LOW_SYNC;
            S_DATA:         low_nxt = shift_nxt[DATA_WIDTH-1] ? LOW_ONE : LOW_ZERO;
            S_PARITY:       low_nxt = parity_nxt ? LOW_ONE : LOW_ZERO;
            default:        low_nxt = '0;
        endcase
        line_nxt = (cnt_nxt >= low_nxt);
    end

    // State, counters, holding register and registered line/done outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            shift_reg  <= '0;
            hold_reg   <= '0;
            hold_full  <= 1'b0;
            parity_reg <= 1'b0;
            data_out   <= 1'b1;
            done_out   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            gap_cnt    <= gap_cnt_nxt;
            shift_reg  <= shift_nxt;
            parity_reg <= parity_nxt;
            data_out   <= line_nxt;
            done_out   <= (state == S_END) && sym_end;
            if (load_start) begin
                hold_full <= 1'b0;
            end else if (valid_in && !hold_full) begin
                hold_full <= 1'b1;
                hold_reg  <= data_in;
            end
        end
    end
endmodule

// File: tb/tb_pwm_frame_tx.sv
// tb/tb_pwm_frame_tx.sv - scoreboard bench for pwm_frame_tx over three parameter sets
module tb_pwm_frame_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          start;
        logic [63:0] w;
    } fr_t;

    task automatic chk(input int inst, input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL i%0d %s: got %0d expected %0d at %0t", inst, name, act, exp, $time);
        end
    endtask

    // Line level k cycles into a frame, derived from the symbol rules.
    function automatic logic exp_level(input logic [63:0] w, input int k, input int dw, input int bp,
                                       input int zl, input int sl, input int ol, input int pe);
        int sym, ph, low;
        sym = k / bp;
        ph  = k % bp;
        if (sym == 0 || sym == dw + pe + 1) low = sl;
        else if (sym <= dw)                 low = w[dw - sym] ? ol : zl;
        else                                low = (^w) ? ol : zl;
        return ph >= low;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int DW   = (gi == 0) ? 26 : (gi == 1) ? 8 : 4;
        localparam int BP   = (gi == 2) ? 8 : 20;
        localparam int ZL   = (gi == 2) ? 2 : 5;
        localparam int SL   = (gi == 2) ? 4 : 10;
        localparam int OL   = (gi == 2) ? 6 : 15;
        localparam int PE   = (gi == 1) ? 1 : 0;
        localparam int GAP  = (gi == 1) ? 7 : 0;
        localparam int LEN  = (DW + PE + 2) * BP;
        localparam int FLEN = (gi == 0) ? 560 : (gi == 1) ? 220 : 48;
        localparam logic [63:0] DIR0 = (gi == 0) ? 64'h2AAAAAA : (gi == 1) ? 64'h07 : 64'h9;
        localparam logic [63:0] DIR1 = (gi == 0) ? 64'h1555555 : (gi == 1) ? 64'h03 : 64'h6;

        logic          rst_n = 1'b0;
        logic          valid = 1'b0;
        logic [DW-1:0] din = '0;
        logic          ready, line, busy, done;
        int            cyc = 0;
        int            free_at = 0;
        fr_t           sb[$];
        bit            fin = 1'b0;
        int            cur_start = 0;
        logic [63:0]   cur_w = '0;
        bit            cur_v = 1'b0;
        int            prev_done = -1;

        pwm_frame_tx #(
            .DATA_WIDTH(DW), .BIT_PERIOD(BP), .ZERO_LOW(ZL), .SYNC_LOW(SL),
            .ONE_LOW(OL), .PARITY_EN(PE), .IDLE_GAP(GAP)
        ) dut (
            .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .data_in(din),
            .ready_out(ready), .data_out(line), .busy_out(busy), .done_out(done)
        );

        // Handshake recorder: each accepted word gets the cycle its frame must start on.
        always @(posedge clk) begin
            if (!rst_n) begin
                sb.delete();
                free_at = 0;
            end else if (valid && ready) begin
                fr_t f;
                f.start = (cyc + 2 > free_at) ? cyc + 2 : free_at;
                f.w     = 64'(din);
                sb.push_back(f);
                free_at = f.start + LEN + GAP;
            end
            cyc = cyc + 1;
        end

        // Monitor: compares line, busy, done and ready every cycle against the frame timeline.
        always @(negedge clk) begin
            int   k;
            logic ed, eb, edn;
            if (!rst_n) begin
                cur_v     = 1'b0;
                prev_done = -1;
                chk(gi, "rst_line", line, 1);
                chk(gi, "rst_ready", ready, 1);
                chk(gi, "rst_busy", busy, 0);
                chk(gi, "rst_done", done, 0);
            end else begin
                if (sb.size() > 0 && sb[0].start == cyc) begin
                    if (cur_v) prev_done = cur_start + LEN;
                    cur_start = sb[0].start;
                    cur_w     = sb[0].w;
                    cur_v     = 1'b1;
                    void'(sb.pop_front());
                end
                k  = cyc - cur_start;
                ed = 1'b1;
                eb = 1'b0;
                if (cur_v && k < LEN) begin
                    ed = exp_level(cur_w, k, DW, BP, ZL, SL, OL, PE);
                    eb = 1'b1;
                end else if (cur_v && k < LEN + GAP) begin
                    eb = 1'b1;
                end
                edn = (cur_v && k == LEN) || (cyc == prev_done);
                chk(gi, "line", line, ed);
                chk(gi, "busy", busy, eb);
                chk(gi, "done", done, edn);
                chk(gi, "ready", ready, sb.size() == 0);
            end
        end

        task automatic send(input logic [DW-1:0] w);
            int n = 0;
            valid = 1'b1;
            din   = w;
            while (!ready && n < 4000) begin
                @(negedge clk);
                n++;
            end
            chk(gi, "accept_in_time", n < 4000, 1);
            @(negedge clk);
            valid = 1'b0;
            din   = DW'({$urandom(), $urandom()});
        endtask

        task automatic measure();
            int n = 0;
            int low = 0;
            int len = 0;
            while (line && n < 100) begin
                @(negedge clk);
                n++;
            end
            while (!done && len < 3000) begin
                if (!line && len == low) low++;
                @(negedge clk);
                len++;
            end
            chk(gi, "start_sync_low", low, SL);
            chk(gi, "frame_len", len, FLEN);
        endtask

        task automatic wait_idle();
            int n = 0;
            while ((busy || !ready) && n < 5000) begin
                @(negedge clk);
                n++;
            end
            chk(gi, "idle_in_time", n < 5000, 1);
            repeat (2) @(negedge clk);
        endtask

        // Stimulus: directed words, back-to-back burst, random traffic, reset mid-frame.
        initial begin
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            send(DW'(DIR0));
            measure();
            wait_idle();
            send(DW'(DIR1));
            measure();
            wait_idle();
            for (int i = 0; i < 3; i++) send(DW'({$urandom(), $urandom()}));
            wait_idle();
            for (int i = 0; i < 6; i++) begin
                send(DW'({$urandom(), $urandom()}));
                repeat ($urandom_range(0, LEN + 10)) @(negedge clk);
            end
            wait_idle();
            send(DW'({$urandom(), $urandom()}));
            send(DW'({$urandom(), $urandom()}));
            repeat (3 * BP) @(negedge clk);
            chk(gi, "held_ready", ready, 0);
            #2 rst_n = 1'b0;
            #1;
            chk(gi, "async_line", line, 1);
            chk(gi, "async_ready", ready, 1);
            chk(gi, "async_busy", busy, 0);
            repeat (3) @(negedge clk);
            #2 rst_n = 1'b1;
            repeat (2 * LEN) @(negedge clk);
            send(DW'({$urandom(), $urandom()}));
            measure();
            wait_idle();
            fin = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(g[0].fin && g[1].fin && g[2].fin) && n < 80000) begin
            @(negedge clk);
            n++;
        end
        chk(-1, "all_done_in_time", n < 80000, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
